// File: rtl/perf_counter_arbiter.sv
// Round-robin arbiter that shares one performance-counter control slave between
// NUM_REQ requesters and keeps the destructive global-reset write with a single owner.
module perf_counter_arbiter #(
   parameter int NUM_REQ     = 2,
   parameter int ADDR_W      = 5,
   parameter int DATA_W      = 32,
   parameter int RESET_OWNER = 0
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ-1:0]          req_write,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
   input  logic [NUM_REQ*DATA_W-1:0]   req_writedata,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic [NUM_REQ-1:0]          rsp_valid,
   output logic [DATA_W-1:0]           rsp_readdata,
   output logic [NUM_REQ-1:0]          rsp_denied,
   output logic [ADDR_W-1:0]           m_address,
   output logic                        m_write,
   output logic                        m_begintransfer,
   output logic [DATA_W-1:0]           m_writedata,
   input  logic [DATA_W-1:0]           m_readdata
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   // Handshake: a requester holds req_valid and payload until the cycle in which
   // req_ready pulses; rsp_valid later pulses once for that accepted request.
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [IDX_W-1:0]  last_grant;
   logic [IDX_W-1:0]  cur;
   logic [IDX_W-1:0]  winner;
   logic [IDX_W-1:0]  hi_idx;
   logic [IDX_W-1:0]  lo_idx;
   logic              any_hi;
   logic              any_lo;
   logic              any_req;
   logic              grant;
   logic              lat_write;
   logic              lat_denied;
   logic [DATA_W-1:0] rd_q;
   logic              sel_write;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              strip;

   // Round robin: lowest requesting index above last_grant, else lowest at or below it.
   always_comb begin
      any_hi = 1'b0;
      any_lo = 1'b0;
      hi_idx = '0;
      lo_idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            if (i > int'(last_grant)) begin
               any_hi = 1'b1;
               hi_idx = IDX_W'(i);
            end else begin
               any_lo = 1'b1;
               lo_idx = IDX_W'(i);
            end
         end
      end
      any_req = any_hi | any_lo;
      winner  = any_hi ? hi_idx : lo_idx;
   end

   assign grant = (state == IDLE) && any_req;

   always_comb begin
      sel_write = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner == IDX_W'(i)) begin
            sel_write = req_write[i];
            sel_addr  = req_address[i*ADDR_W +: ADDR_W];
            sel_wdata = req_writedata[i*DATA_W +: DATA_W];
         end
      end
   end

   // Only the owner may set the global-reset bit; others still get the write, minus bit 0.
   assign strip = sel_write && (sel_addr == '0) && sel_wdata[0] &&
                  (winner != IDX_W'(RESET_OWNER));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = ISSUE;
         ISSUE:   state_nxt = lat_write ? RESP : WAIT;
         WAIT:    state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Bus address/data are only reloaded on a grant so the slave readdata mux never glitches.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         last_grant  <= IDX_W'(NUM_REQ - 1);
         cur         <= '0;
         lat_write   <= 1'b0;
         lat_denied  <= 1'b0;
         m_address   <= '0;
         m_writedata <= '0;
         rd_q        <= '0;
      end else begin
         if (grant) begin
            last_grant  <= winner;
            cur         <= winner;
            lat_write   <= sel_write;
            lat_denied  <= strip;
            m_address   <= sel_addr;
            m_writedata <= {sel_wdata[DATA_W-1:1], sel_wdata[0] & ~strip};
         end
         if (state == WAIT) begin
            rd_q <= m_readdata;
         end
      end
   end

   always_comb begin
      req_ready       = '0;
      rsp_valid       = '0;
      rsp_denied      = '0;
      m_begintransfer = (state == ISSUE);
      m_write         = (state == ISSUE) && lat_write;
      rsp_readdata    = ((state == RESP) && !lat_write) ? rd_q : '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i]  = grant && reset_n && (winner == IDX_W'(i));
         rsp_valid[i]  = (state == RESP) && (cur == IDX_W'(i));
         rsp_denied[i] = (state == RESP) && (cur == IDX_W'(i)) && lat_denied;
      end
   end

   a_ready_onehot : assert property (@(posedge clk) disable iff (!reset_n) $onehot0(req_ready));
   a_rsp_onehot   : assert property (@(posedge clk) disable iff (!reset_n) $onehot0(rsp_valid));
   a_denied_sub   : assert property (@(posedge clk) disable iff (!reset_n) (rsp_denied & ~rsp_valid) == '0);

endmodule

// File: tb/tb_perf_counter_arbiter.sv
// Directed bench for perf_counter_arbiter: one task per scenario, each checking
// hand-computed values against a simple registered-readdata slave model.
module tb_perf_counter_arbiter;

   localparam int NUM_REQ = 2;
   localparam int ADDR_W  = 5;
   localparam int DATA_W  = 32;

   logic                      clk = 1'b0;
   logic                      reset_n;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_write;
   logic [NUM_REQ*ADDR_W-1:0] req_address;
   logic [NUM_REQ*DATA_W-1:0] req_writedata;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]         rsp_readdata;
   logic [NUM_REQ-1:0]        rsp_denied;
   logic [ADDR_W-1:0]         m_address;
   logic                      m_write;
   logic                      m_begintransfer;
   logic [DATA_W-1:0]         m_writedata;
   logic [DATA_W-1:0]         m_readdata = '0;

   logic [DATA_W-1:0]         last_wdata = '0;
   int                        n_checks = 0;
   int                        n_fail = 0;

   perf_counter_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_OWNER(0)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_write(req_write),
      .req_address(req_address), .req_writedata(req_writedata),
      .req_ready(req_ready), .rsp_valid(rsp_valid),
      .rsp_readdata(rsp_readdata), .rsp_denied(rsp_denied),
      .m_address(m_address), .m_write(m_write),
      .m_begintransfer(m_begintransfer), .m_writedata(m_writedata),
      .m_readdata(m_readdata)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   // Slave model: word at address a reads as 0x40 + a, one cycle after the address.
   always @(posedge clk) begin
      m_readdata <= 32'h40 + {27'h0, m_address};
      if (m_begintransfer && m_write) last_wdata <= m_writedata;
   end

   // driver tasks
   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic w,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      req_valid[i] = v;
      req_write[i] = w;
      req_address[i*ADDR_W +: ADDR_W] = a;
      req_writedata[i*DATA_W +: DATA_W] = d;
   endtask

   task automatic apply_reset;
      reset_n = 1'b0;
      req_valid = '0;
      req_write = '0;
      req_address = '0;
      req_writedata = '0;
      next_cycle();
      next_cycle();
      reset_n = 1'b1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      req_valid = '0;
      req_write = '0;
      req_address = '0;
      req_writedata = '0;
      next_cycle();
      @(negedge clk);
      n_checks++; if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || rsp_denied !== 2'b00) begin n_fail++; $display("FAIL reset_handshake: got %b/%b/%b want 00/00/00", req_ready, rsp_valid, rsp_denied); end
      n_checks++; if (m_write !== 1'b0 || m_begintransfer !== 1'b0 || m_address !== 5'd0) begin n_fail++; $display("FAIL reset_bus: got %b/%b/%h want 0/0/00", m_write, m_begintransfer, m_address); end
      n_checks++; if (m_writedata !== 32'h0 || rsp_readdata !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h/%h want 0/0", m_writedata, rsp_readdata); end
      next_cycle();
      reset_n = 1'b1;
   endtask

   task automatic test_read;
      set_req(0, 1'b1, 1'b0, 5'd2, 32'h0);
      @(negedge clk);
      n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL read_grant: got %b want 01", req_ready); end
      n_checks++; if (m_begintransfer !== 1'b0) begin n_fail++; $display("FAIL read_bt_early: got %b want 0", m_begintransfer); end
      next_cycle();
      set_req(0, 1'b0, 1'b0, 5'd2, 32'h0);
      @(negedge clk);
      n_checks++; if (m_begintransfer !== 1'b1 || m_write !== 1'b0 || m_address !== 5'd2) begin n_fail++; $display("FAIL read_issue: got bt=%b wr=%b a=%h want 1/0/02", m_begintransfer, m_write, m_address); end
      n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL read_ready_issue: got %b want 00", req_ready); end
      next_cycle();
      @(negedge clk);
      n_checks++; if (m_begintransfer !== 1'b0 || rsp_valid !== 2'b00 || m_address !== 5'd2) begin n_fail++; $display("FAIL read_wait: got bt=%b rv=%b a=%h want 0/00/02", m_begintransfer, rsp_valid, m_address); end
      next_cycle();
      @(negedge clk);
      n_checks++; if (rsp_valid !== 2'b01 || rsp_denied !== 2'b00) begin n_fail++; $display("FAIL read_rsp: got rv=%b rd=%b want 01/00", rsp_valid, rsp_denied); end
      n_checks++; if (rsp_readdata !== 32'h42) begin n_fail++; $display("FAIL read_data: got %h want 00000042", rsp_readdata); end
      next_cycle();
   endtask

   task automatic test_write;
      set_req(1, 1'b1, 1'b1, 5'd1, 32'h0);
      @(negedge clk);
      n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL write_grant: got %b want 10", req_ready); end
      next_cycle();
      set_req(1, 1'b0, 1'b0, 5'd1, 32'h0);
      @(negedge clk);
      n_checks++; if (m_write !== 1'b1 || m_begintransfer !== 1'b1 || m_address !== 5'd1 || m_writedata !== 32'h0) begin n_fail++; $display("FAIL write_issue: got wr=%b bt=%b a=%h d=%h want 1/1/01/0", m_write, m_begintransfer, m_address, m_writedata); end
      next_cycle();
      @(negedge clk);
      n_checks++; if (rsp_valid !== 2'b10 || rsp_denied !== 2'b00 || rsp_readdata !== 32'h0) begin n_fail++; $display("FAIL write_rsp: got rv=%b dn=%b rd=%h want 10/00/0", rsp_valid, rsp_denied, rsp_readdata); end
      n_checks++; if (m_write !== 1'b0 || m_begintransfer !== 1'b0 || m_address !== 5'd1) begin n_fail++; $display("FAIL write_bus_idle: got wr=%b bt=%b a=%h want 0/0/01", m_write, m_begintransfer, m_address); end
      next_cycle();
   endtask

   task automatic test_round_robin;
      int exp_q[$];
      int got_q[$];
      int cnt0;
      int cnt1;
      cnt0 = 0;
      cnt1 = 0;
      exp_q = '{0, 1, 0, 1, 0, 1, 0, 1};
      apply_reset();
      set_req(0, 1'b1, 1'b0, 5'd3, 32'h0);
      set_req(1, 1'b1, 1'b0, 5'd4, 32'h0);
      for (int c = 0; c < 32; c++) begin
         @(negedge clk);
         if (req_ready != 2'b00) got_q.push_back(req_ready[1] ? 1 : 0);
         if (rsp_valid[0]) begin
            cnt0++;
            n_checks++; if (rsp_readdata !== 32'h43) begin n_fail++; $display("FAIL rr_data0: got %h want 00000043", rsp_readdata); end
         end
         if (rsp_valid[1]) begin
            cnt1++;
            n_checks++; if (rsp_readdata !== 32'h44) begin n_fail++; $display("FAIL rr_data1: got %h want 00000044", rsp_readdata); end
         end
         n_checks++; if (!$onehot0(req_ready) || !$onehot0(rsp_valid) || (rsp_denied & ~rsp_valid) != 2'b00) begin n_fail++; $display("FAIL rr_onehot: got rdy=%b rv=%b dn=%b want one-hot", req_ready, rsp_valid, rsp_denied); end
         next_cycle();
      end
      req_valid = '0;
      n_checks++; if (cnt0 != 4 || cnt1 != 4) begin n_fail++; $display("FAIL rr_counts: got %0d/%0d want 4/4", cnt0, cnt1); end
      n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rr_grant_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         int e;
         int g;
         e = exp_q.pop_front();
         g = got_q.pop_front();
         n_checks++; if (g != e) begin n_fail++; $display("FAIL rr_order: got %0d want %0d", g, e); end
      end
   endtask

   task automatic test_guard;
      set_req(1, 1'b1, 1'b1, 5'd0, 32'h1);
      @(negedge clk);
      n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL guard1_grant: got %b want 10", req_ready); end
      next_cycle();
      req_valid = '0;
      @(negedge clk);
      n_checks++; if (m_writedata !== 32'h0 || m_write !== 1'b1 || m_address !== 5'd0) begin n_fail++; $display("FAIL guard1_bus: got d=%h wr=%b a=%h want 0/1/00", m_writedata, m_write, m_address); end
      next_cycle();
      @(negedge clk);
      n_checks++; if (rsp_valid !== 2'b10 || rsp_denied !== 2'b10) begin n_fail++; $display("FAIL guard1_rsp: got rv=%b dn=%b want 10/10", rsp_valid, rsp_denied); end
      n_checks++; if (last_wdata !== 32'h0) begin n_fail++; $display("FAIL guard1_slave: got %h want 0", last_wdata); end
      next_cycle();
      set_req(0, 1'b1, 1'b1, 5'd0, 32'h1);
      @(negedge clk);
      n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL guard0_grant: got %b want 01", req_ready); end
      next_cycle();
      req_valid = '0;
      @(negedge clk);
      n_checks++; if (m_writedata !== 32'h1) begin n_fail++; $display("FAIL guard0_bus: got %h want 1", m_writedata); end
      next_cycle();
      @(negedge clk);
      n_checks++; if (rsp_valid !== 2'b01 || rsp_denied !== 2'b00) begin n_fail++; $display("FAIL guard0_rsp: got rv=%b dn=%b want 01/00", rsp_valid, rsp_denied); end
      n_checks++; if (last_wdata !== 32'h1) begin n_fail++; $display("FAIL guard0_slave: got %h want 1", last_wdata); end
      next_cycle();
   endtask

   task automatic test_reset_mid;
      set_req(0, 1'b1, 1'b0, 5'd2, 32'h0);
      next_cycle();
      req_valid = '0;
      next_cycle();
      reset_n = 1'b0;
      @(negedge clk);
      n_checks++; if (m_begintransfer !== 1'b0 || m_address !== 5'd2) begin n_fail++; $display("FAIL mid_wait: got bt=%b a=%h want 0/02", m_begintransfer, m_address); end
      next_cycle();
      @(negedge clk);
      n_checks++; if (rsp_valid !== 2'b00 || req_ready !== 2'b00 || rsp_denied !== 2'b00 || rsp_readdata !== 32'h0) begin n_fail++; $display("FAIL mid_rsp_zero: got rv=%b rdy=%b dn=%b rd=%h want 0", rsp_valid, req_ready, rsp_denied, rsp_readdata); end
      n_checks++; if (m_address !== 5'd0 || m_writedata !== 32'h0 || m_write !== 1'b0 || m_begintransfer !== 1'b0) begin n_fail++; $display("FAIL mid_bus_zero: got a=%h d=%h wr=%b bt=%b want 0", m_address, m_writedata, m_write, m_begintransfer); end
      next_cycle();
      reset_n = 1'b1;
      set_req(0, 1'b1, 1'b0, 5'd2, 32'h0);
      set_req(1, 1'b1, 1'b0, 5'd3, 32'h0);
      @(negedge clk);
      n_checks++; if (req_ready !== 2'b01 || rsp_valid !== 2'b00) begin n_fail++; $display("FAIL mid_first_grant: got rdy=%b rv=%b want 01/00", req_ready, rsp_valid); end
      next_cycle();
      req_valid[0] = 1'b0;
      next_cycle();
      next_cycle();
      @(negedge clk);
      n_checks++; if (rsp_valid !== 2'b01 || rsp_readdata !== 32'h42) begin n_fail++; $display("FAIL mid_rsp0: got rv=%b rd=%h want 01/00000042", rsp_valid, rsp_readdata); end
      next_cycle();
      @(negedge clk);
      n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL mid_second_grant: got %b want 10", req_ready); end
      next_cycle();
      req_valid = '0;
      next_cycle();
      next_cycle();
      next_cycle();
   endtask

   task automatic test_withdraw;
      set_req(1, 1'b1, 1'b0, 5'd4, 32'h0);
      @(negedge clk);
      n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL wd_grant: got %b want 10", req_ready); end
      next_cycle();
      set_req(1, 1'b0, 1'b0, 5'd4, 32'h0);
      set_req(0, 1'b1, 1'b0, 5'd2, 32'h0);
      @(negedge clk);
      n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL wd_busy_ready: got %b want 00", req_ready); end
      next_cycle();
      req_valid = '0;
      next_cycle();
      @(negedge clk);
      n_checks++; if (rsp_valid !== 2'b10 || rsp_readdata !== 32'h44) begin n_fail++; $display("FAIL wd_rsp: got rv=%b rd=%h want 10/00000044", rsp_valid, rsp_readdata); end
      for (int c = 0; c < 6; c++) begin
         next_cycle();
         @(negedge clk);
         n_checks++; if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || m_begintransfer !== 1'b0) begin n_fail++; $display("FAIL wd_quiet: got rdy=%b rv=%b bt=%b want 00/00/0", req_ready, rsp_valid, m_begintransfer); end
      end
      next_cycle();
   endtask

   initial begin
      reset_n = 1'b0;
      req_valid = '0;
      req_write = '0;
      req_address = '0;
      req_writedata = '0;
      test_reset();
      test_read();
      test_write();
      test_round_robin();
      test_guard();
      test_reset_mid();
      test_withdraw();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/perf_counter_arbiter.md
Name: perf_counter_arbiter

Overview:
- Shares one performance-counter control slave (32 word-addressed registers, registered readdata with 1-cycle latency) between NUM_REQ processor-side requesters.
- Arbitrates round-robin and sequences each access as a single begintransfer-qualified command, then returns read data or a write acknowledge.
- Restricts the destructive global-reset write (address 0, writedata[0]=1) to one owning requester, so one core cannot clear another core's measurements.
- Sits between the per-core interconnect ports and the counter slave in the multi-core system.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 5, counter slave word-address width.
- DATA_W, 32, data width.
- RESET_OWNER, 0, index of the only requester allowed to issue global reset.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_address  in  NUM_REQ*ADDR_W  packed word addresses; requester i occupies slice i.
- req_writedata  in  NUM_REQ*DATA_W  packed write data.
- req_ready  out  NUM_REQ  one-cycle grant/accept pulse.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse.
- rsp_readdata  out  DATA_W  read data; valid only while rsp_valid is nonzero.
- rsp_denied  out  NUM_REQ  pulses with rsp_valid when a global-reset bit was stripped.
- m_address  out  ADDR_W  to counter slave.
- m_write  out  1  to counter slave.
- m_begintransfer  out  1  to counter slave.
- m_writedata  out  DATA_W  to counter slave.
- m_readdata  in  DATA_W  from counter slave.

Behaviour:
- Reset applies on any clk edge with reset_n=0, including mid-transaction:
  - state returns to IDLE and every output is driven to 0;
  - the round-robin pointer is set to last_grant=NUM_REQ-1, so requester 0 has highest priority;
  - an in-flight transaction is abandoned with no response.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, select the winner: first set bit searching upward from last_grant+1, wrapping modulo NUM_REQ.
  - Pulse req_ready[winner]; latch the winner's write, address and writedata.
  - Set last_grant=winner; go to ISSUE.
  - If no req_valid is set, stay in IDLE.
- ISSUE, exactly one cycle:
  - m_begintransfer=1, m_write=latched write, m_address and m_writedata = latched values.
  - Next state: WAIT for a read, RESP for a write.
- WAIT, read only:
  - m_begintransfer=0, m_write=0, m_address held.
  - Slave readdata now reflects the address; capture m_readdata into rsp_readdata at the end of this cycle.
- RESP:
  - rsp_valid[winner]=1 for one cycle; rsp_readdata holds captured data for a read, 0 for a write.
  - Return to IDLE.
- Latency:
  - Read: req_ready to rsp_valid = 3 cycles.
  - Write: req_ready to rsp_valid = 2 cycles.
  - Minimum request spacing: 4 cycles (read), 3 cycles (write).
- Bus outputs outside ISSUE:
  - m_write=0 and m_begintransfer=0 at all times outside ISSUE.
  - m_address and m_writedata keep their last value (no glitching of the readdata mux).
- Requester rules:
  - Hold req_valid and payload stable until req_ready.
  - Dropping req_valid before grant withdraws the request; no error.
  - A new request from the same requester is legal in the cycle after its rsp_valid.
  - Arbitration looks only at req_valid while in IDLE; requests arriving in other states wait.
- Global-reset guard:
  - Applies when the winner is not RESET_OWNER and the request is a write to address 0 with writedata[0]=1.
  - m_writedata[0] is forced to 0; the stop still executes.
  - rsp_denied[winner] pulses together with rsp_valid.
  - RESET_OWNER writes pass through unmodified.
  - Reads and all other addresses are never modified.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers keep waiting and are served in rotation; no requester starves. Bound: (NUM_REQ-1) transactions of wait.
- One-hot invariants: req_ready and rsp_valid are one-hot or zero; rsp_denied is a subset of rsp_valid.

Test Plan:
- Reset, then req 0 reads address 2 with slave returning 0x0000_0042 → req_ready[0] at T, m_begintransfer only at T+1 with m_address=2, rsp_valid[0] at T+3 with rsp_readdata=0x42.
- Req 1 writes address 1 data 0 → m_write=m_begintransfer=1 for one cycle at T+1, rsp_valid[1] at T+2, rsp_readdata=0, rsp_denied=0.
- Req 0 and req 1 continuously valid reads after reset → grants alternate 0,1,0,1; each requester gets exactly 4 responses in 32 cycles.
- Req 1 writes address 0 data 0x1 → slave sees m_writedata=0x0, rsp_denied[1]=1; repeat from req 0 → slave sees 0x1, rsp_denied=0.
- Assert reset_n=0 during WAIT of a read → next cycle all outputs 0, no rsp_valid; after release, simultaneous req 0/1 → req 0 granted first.
- Req 0 withdraws req_valid while req 1's transaction is in WAIT → after RESP, req 0 is never granted, no spurious outputs.
